// File: rtl/adc_trigger_ctrl_if.sv
// Capture-side bus between the trigger stage and the DPRAM ADC write controller.
// The delayed sample stream and start level go downstream, and buffer-full status comes back.
interface adc_trigger_ctrl_if;
    logic [31:0] adc_sample_o;
    logic        acq_start_o;
    logic        acq_done_i;

    modport master (output adc_sample_o, output acq_start_o, input acq_done_i);
    modport slave  (input adc_sample_o, input acq_start_o, output acq_done_i);
endinterface

// File: rtl/adc_trigger_ctrl.sv
// ADC capture trigger: immediate, edge/threshold with hysteresis, and auto (timeout-forced) modes.
// Trigger latency is 2 cycles from the crossing sample; the sample stream is delayed PIPE_DLY cycles.
module adc_trigger_ctrl #(
    parameter int DATA_W   = 16,
    parameter int TMO_W    = 24,
    parameter int PIPE_DLY = 2
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic [31:0]              adc_sample_in,
    adc_trigger_ctrl_if.master       wr,
    input  logic                     csr_arm_i,
    input  logic [1:0]               csr_mode_i,
    input  logic                     csr_src_i,
    input  logic                     csr_edge_i,
    input  logic [DATA_W-1:0]        csr_level_i,
    input  logic [DATA_W-1:0]        csr_hyst_i,
    input  logic [TMO_W-1:0]         csr_timeout_i,
    output logic [2:0]               csr_state_o,
    output logic                     csr_forced_o,
    output logic [15:0]              csr_trig_cnt_o
);
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMING  = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam int EW = DATA_W + 2;
    localparam logic signed [EW-1:0] SAT_MAX = EW'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [EW-1:0] SAT_MIN = ~SAT_MAX;

    state_t                    r_state, w_next;
    logic [31:0]               r_pipe [PIPE_DLY];
    logic [1:0]                r_mode;
    logic                      r_src, r_edge, r_forced, r_start;
    logic signed [DATA_W-1:0]  r_level;
    logic [DATA_W-1:0]         r_hyst;
    logic [TMO_W-1:0]          r_timeout, r_tmo;
    logic [15:0]               r_trig_cnt;

    logic                      w_exit_idle, w_pre, w_trig, w_tmo_hit, w_set_forced;
    logic signed [DATA_W-1:0]  w_s, w_thr;
    logic signed [EW-1:0]      w_level_x, w_hyst_x, w_sum;

    assign w_exit_idle = (r_state == ST_IDLE) && csr_arm_i;

    // Stage 0 of the delay line doubles as the registered compare sample.
    assign w_s = r_src ? r_pipe[0][16 +: DATA_W] : r_pipe[0][DATA_W-1:0];

    // Two guard bits so even full-scale hysteresis cannot wrap before saturation.
    assign w_level_x = {{2{r_level[DATA_W-1]}}, r_level};
    assign w_hyst_x  = {2'b00, r_hyst};
    assign w_sum     = r_edge ? (w_level_x + w_hyst_x) : (w_level_x - w_hyst_x);

    always_comb begin
        w_thr = w_sum[DATA_W-1:0];
        if (w_sum > SAT_MAX) begin
            w_thr = SAT_MAX[DATA_W-1:0];
        end else if (w_sum < SAT_MIN) begin
            w_thr = SAT_MIN[DATA_W-1:0];
        end
    end

    assign w_pre     = r_edge ? (w_s > w_thr) : (w_s < w_thr);
    assign w_trig    = r_edge ? (w_s <= r_level) : (w_s >= r_level);
    assign w_tmo_hit = (r_mode == 2'd2) && (r_timeout != '0) && (r_tmo == r_timeout - TMO_W'(1));

    always_comb begin
        w_next       = r_state;
        w_set_forced = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (csr_arm_i) begin
                    w_next = (csr_mode_i == 2'd0) ? ST_CAPTURE : ST_ARMING;
                end
            end
            ST_ARMING: begin
                if (!csr_arm_i) begin
                    w_next = ST_IDLE;
                end else if (w_tmo_hit) begin
                    w_next       = ST_CAPTURE;
                    w_set_forced = 1'b1;
                end else if (w_pre) begin
                    w_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A real trigger outranks a coincident timeout.
                if (!csr_arm_i) begin
                    w_next = ST_IDLE;
                end else if (w_trig) begin
                    w_next = ST_CAPTURE;
                end else if (w_tmo_hit) begin
                    w_next       = ST_CAPTURE;
                    w_set_forced = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (!csr_arm_i) begin
                    w_next = ST_IDLE;
                end else if (wr.acq_done_i) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!csr_arm_i) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int i = 0; i < PIPE_DLY; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= adc_sample_in;
            for (int i = 1; i < PIPE_DLY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state    <= ST_IDLE;
            r_start    <= 1'b0;
            r_mode     <= '0;
            r_src      <= 1'b0;
            r_edge     <= 1'b0;
            r_level    <= '0;
            r_hyst     <= '0;
            r_timeout  <= '0;
            r_tmo      <= '0;
            r_forced   <= 1'b0;
            r_trig_cnt <= '0;
        end else begin
            r_state <= w_next;
            r_start <= (w_next == ST_CAPTURE) || (w_next == ST_DONE);
            if (w_exit_idle) begin
                r_mode    <= csr_mode_i;
                r_src     <= csr_src_i;
                r_edge    <= csr_edge_i;
                r_level   <= csr_level_i;
                r_hyst    <= csr_hyst_i;
                r_timeout <= csr_timeout_i;
            end
            if (r_state == ST_IDLE && w_next == ST_ARMING) begin
                r_tmo    <= '0;
                r_forced <= 1'b0;
            end else if (r_state == ST_ARMING || r_state == ST_WAIT) begin
                r_tmo <= r_tmo + TMO_W'(1);
            end
            if (w_set_forced) begin
                r_forced <= 1'b1;
            end
            if (w_next == ST_CAPTURE && r_state != ST_CAPTURE) begin
                r_trig_cnt <= r_trig_cnt + 16'd1;
            end
        end
    end

    assign wr.adc_sample_o = r_pipe[PIPE_DLY-1];
    assign wr.acq_start_o  = r_start;
    assign csr_state_o     = r_state;
    assign csr_forced_o    = r_forced;
    assign csr_trig_cnt_o  = r_trig_cnt;
endmodule

// File: tb/tb_adc_trigger_ctrl.sv
// Directed bench for adc_trigger_ctrl: trigger modes, disarm, async reset and sample delay line.
module tb_adc_trigger_ctrl;
    logic        sys_clk;
    logic        sys_rst;
    logic [31:0] adc_sample_in;
    logic        csr_arm_i;
    logic [1:0]  csr_mode_i;
    logic        csr_src_i;
    logic        csr_edge_i;
    logic [15:0] csr_level_i;
    logic [15:0] csr_hyst_i;
    logic [23:0] csr_timeout_i;
    logic [2:0]  st0, st1, st8;
    logic        fo0, fo1, fo8;
    logic [15:0] tc0, tc1, tc8;

    adc_trigger_ctrl_if wr0 ();
    adc_trigger_ctrl_if wr1 ();
    adc_trigger_ctrl_if wr8 ();

    adc_trigger_ctrl #(.DATA_W(16), .TMO_W(24), .PIPE_DLY(2)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .adc_sample_in(adc_sample_in), .wr(wr0),
        .csr_arm_i(csr_arm_i), .csr_mode_i(csr_mode_i), .csr_src_i(csr_src_i),
        .csr_edge_i(csr_edge_i), .csr_level_i(csr_level_i), .csr_hyst_i(csr_hyst_i),
        .csr_timeout_i(csr_timeout_i), .csr_state_o(st0), .csr_forced_o(fo0), .csr_trig_cnt_o(tc0));

    adc_trigger_ctrl #(.DATA_W(16), .TMO_W(24), .PIPE_DLY(1)) dut_d1 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .adc_sample_in(adc_sample_in), .wr(wr1),
        .csr_arm_i(csr_arm_i), .csr_mode_i(csr_mode_i), .csr_src_i(csr_src_i),
        .csr_edge_i(csr_edge_i), .csr_level_i(csr_level_i), .csr_hyst_i(csr_hyst_i),
        .csr_timeout_i(csr_timeout_i), .csr_state_o(st1), .csr_forced_o(fo1), .csr_trig_cnt_o(tc1));

    adc_trigger_ctrl #(.DATA_W(16), .TMO_W(24), .PIPE_DLY(8)) dut_d8 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .adc_sample_in(adc_sample_in), .wr(wr8),
        .csr_arm_i(csr_arm_i), .csr_mode_i(csr_mode_i), .csr_src_i(csr_src_i),
        .csr_edge_i(csr_edge_i), .csr_level_i(csr_level_i), .csr_hyst_i(csr_hyst_i),
        .csr_timeout_i(csr_timeout_i), .csr_state_o(st8), .csr_forced_o(fo8), .csr_trig_cnt_o(tc8));

    typedef struct {
        int          lat;
        logic [15:0] cnt;
        logic        forced;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] hist [$];
    int          n_chk = 0;
    int          n_err = 0;

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pops the expected trigger and waits (bounded) for acq_start_o to rise.
    task automatic expect_trig(input string tag, input int budget);
        exp_t e;
        int   n;
        e = sb.pop_front();
        n = 0;
        while (wr0.acq_start_o !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_latency"}, n, e.lat);
        chk({tag, "_trig_cnt"}, {16'd0, tc0}, {16'd0, e.cnt});
        chk({tag, "_forced"}, {31'd0, fo0}, {31'd0, e.forced});
    endtask

    task automatic disarm();
        csr_arm_i = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        sys_rst = 1'b1;
        adc_sample_in = 32'h1234_5678;
        csr_arm_i = 1'b0; csr_mode_i = 2'd0; csr_src_i = 1'b0; csr_edge_i = 1'b0;
        csr_level_i = '0; csr_hyst_i = '0; csr_timeout_i = '0;
        wr0.acq_done_i = 1'b0; wr1.acq_done_i = 1'b0; wr8.acq_done_i = 1'b0;
        repeat (2) step();
        chk("rst_state", {29'd0, st0}, 32'd0);
        chk("rst_start", {31'd0, wr0.acq_start_o}, 32'd0);
        chk("rst_sample_o", wr0.adc_sample_o, 32'd0);
        chk("rst_forced", {31'd0, fo0}, 32'd0);
        chk("rst_trig_cnt", {16'd0, tc0}, 32'd0);
        sys_rst = 1'b0;
        step();

        // Immediate mode, done handling, arm held high, disarm from DONE.
        adc_sample_in = {16'd0, 16'd90};
        csr_mode_i = 2'd0;
        csr_arm_i = 1'b1;
        sb.push_back(exp_t'{lat: 1, cnt: 16'd1, forced: 1'b0});
        expect_trig("imm", 4);
        chk("imm_state", {29'd0, st0}, 32'd3);
        wr0.acq_done_i = 1'b1;
        step();
        wr0.acq_done_i = 1'b0;
        chk("imm_done_state", {29'd0, st0}, 32'd4);
        repeat (3) step();
        chk("imm_hold_state", {29'd0, st0}, 32'd4);
        chk("imm_hold_start", {31'd0, wr0.acq_start_o}, 32'd1);
        chk("imm_hold_cnt", {16'd0, tc0}, 32'd1);
        disarm();
        chk("imm_disarm_state", {29'd0, st0}, 32'd0);
        chk("imm_disarm_start", {31'd0, wr0.acq_start_o}, 32'd0);

        // Rising edge, level 100, hysteresis 20 (lo = 80).
        csr_mode_i = 2'd1; csr_src_i = 1'b0; csr_edge_i = 1'b0;
        csr_level_i = 16'd100; csr_hyst_i = 16'd20;
        csr_arm_i = 1'b1;
        step();
        chk("rise_arming", {29'd0, st0}, 32'd1);
        adc_sample_in = {16'd0, 16'd50};
        step();
        chk("rise_still_arming", {29'd0, st0}, 32'd1);
        adc_sample_in = {16'd0, 16'd70};
        step();
        chk("rise_pre_on_50", {29'd0, st0}, 32'd2);
        adc_sample_in = {16'd0, 16'd85};
        step();
        adc_sample_in = {16'd0, 16'd95};
        step();
        chk("rise_no_early", {31'd0, wr0.acq_start_o}, 32'd0);
        adc_sample_in = {16'd0, 16'd100};
        sb.push_back(exp_t'{lat: 2, cnt: 16'd2, forced: 1'b0});
        expect_trig("rise", 6);
        disarm();

        // Ramp that never drops below lo: stays in ARMING.
        adc_sample_in = {16'd0, 16'd90};
        csr_arm_i = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            adc_sample_in = {16'd0, (i < 2) ? 16'd95 : 16'd100};
            step();
        end
        chk("rise_nopre_state", {29'd0, st0}, 32'd1);
        chk("rise_nopre_start", {31'd0, wr0.acq_start_o}, 32'd0);
        disarm();

        // Falling on chB with hi saturating at 0x7FFF: precondition unreachable.
        csr_src_i = 1'b1; csr_edge_i = 1'b1;
        csr_level_i = 16'h7FF0; csr_hyst_i = 16'h0100;
        adc_sample_in = {16'h7FF5, 16'h0000};
        csr_arm_i = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            adc_sample_in = (i % 3 == 0) ? {16'h7FFF, 16'h0} : (i % 3 == 1) ? {16'h7FF5, 16'h0} : {16'h7F00, 16'h0};
            step();
        end
        chk("fall_sat_state", {29'd0, st0}, 32'd1);
        chk("fall_sat_start", {31'd0, wr0.acq_start_o}, 32'd0);
        disarm();

        // Falling, level -100, hysteresis 10 (hi = -90): -80 then -100.
        csr_level_i = 16'hFF9C; csr_hyst_i = 16'd10;
        adc_sample_in = {16'hFFA1, 16'h0};
        csr_arm_i = 1'b1;
        step();
        adc_sample_in = {16'hFFB0, 16'h0};
        step();
        adc_sample_in = {16'hFF9C, 16'h0};
        sb.push_back(exp_t'{lat: 2, cnt: 16'd3, forced: 1'b0});
        expect_trig("fall", 6);
        disarm();

        // Auto mode, flat input: forced trigger exactly 1000 cycles after ARMING entry.
        csr_mode_i = 2'd2; csr_src_i = 1'b0; csr_edge_i = 1'b0;
        csr_level_i = 16'd100; csr_hyst_i = 16'd20; csr_timeout_i = 24'd1000;
        adc_sample_in = {16'd0, 16'd50};
        csr_arm_i = 1'b1;
        step();
        chk("auto_arming", {29'd0, st0}, 32'd1);
        sb.push_back(exp_t'{lat: 1000, cnt: 16'd4, forced: 1'b1});
        expect_trig("auto_forced", 1100);
        disarm();
        chk("auto_forced_kept", {31'd0, fo0}, 32'd1);

        // Real crossing lands on the timeout cycle: real trigger wins.
        csr_timeout_i = 24'd20;
        csr_arm_i = 1'b1;
        step();
        chk("auto_forced_cleared", {31'd0, fo0}, 32'd0);
        repeat (18) step();
        adc_sample_in = {16'd0, 16'd100};
        sb.push_back(exp_t'{lat: 2, cnt: 16'd5, forced: 1'b0});
        expect_trig("auto_tie", 4);
        disarm();

        // Disarm in WAIT_TRIG.
        csr_mode_i = 2'd1;
        adc_sample_in = {16'd0, 16'd90};
        csr_arm_i = 1'b1;
        step();
        adc_sample_in = {16'd0, 16'd50};
        repeat (2) step();
        chk("dis_wait_pre", {29'd0, st0}, 32'd2);
        disarm();
        chk("dis_wait_state", {29'd0, st0}, 32'd0);
        chk("dis_wait_start", {31'd0, wr0.acq_start_o}, 32'd0);
        chk("dis_wait_cnt", {16'd0, tc0}, 32'd5);

        // Disarm in CAPTURE.
        csr_mode_i = 2'd0;
        csr_arm_i = 1'b1;
        sb.push_back(exp_t'{lat: 1, cnt: 16'd6, forced: 1'b0});
        expect_trig("imm2", 4);
        disarm();
        chk("dis_cap_state", {29'd0, st0}, 32'd0);
        chk("dis_cap_start", {31'd0, wr0.acq_start_o}, 32'd0);
        chk("dis_cap_cnt", {16'd0, tc0}, 32'd6);

        // Asynchronous reset mid-CAPTURE, checked between clock edges.
        csr_arm_i = 1'b1;
        sb.push_back(exp_t'{lat: 1, cnt: 16'd7, forced: 1'b0});
        expect_trig("imm3", 4);
        chk("pre_rst_sample_o", wr0.adc_sample_o, {16'd0, 16'd50});
        #2;
        sys_rst = 1'b1;
        #1;
        chk("arst_state", {29'd0, st0}, 32'd0);
        chk("arst_start", {31'd0, wr0.acq_start_o}, 32'd0);
        chk("arst_sample_o", wr0.adc_sample_o, 32'd0);
        chk("arst_forced", {31'd0, fo0}, 32'd0);
        chk("arst_trig_cnt", {16'd0, tc0}, 32'd0);
        csr_arm_i = 1'b0;
        step();
        sys_rst = 1'b0;
        step();

        // Delay line against a history of driven samples, PIPE_DLY = 1, 2, 8.
        for (int i = 0; i < 24; i++) begin
            logic [31:0] x;
            x = $urandom;
            adc_sample_in = x;
            step();
            hist.push_front(x);
            chk("pipe_d1", wr1.adc_sample_o, hist[0]);
            if (hist.size() >= 2) chk("pipe_d2", wr0.adc_sample_o, hist[1]);
            if (hist.size() >= 8) chk("pipe_d8", wr8.adc_sample_o, hist[7]);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
